vector_list_sequencer: RTL and testbench
========================================

Name: vector_list_sequencer

Overview:
- Walks a vector command list in synchronous ROM/RAM once per frame and feeds segment endpoints to the line drawer using a go/busy handshake.
- Parametrised successor to the single-shot vector master FSM; adds configurable width/depth and memory latency, an opcode-based command set, end-of-list handling, coordinate clamping, and frame restart with overrun flagging.
- Sits between the vector list memory and the line drawer in the vector display path.

Parameters:
- OUT_WIDTH, 8, coordinate width in bits.
- ADDR_WIDTH, 10, list memory address width; list depth is 2**ADDR_WIDTH.
- MEM_LATENCY, 1, cycles from rd_en to valid rd_data; legal range 1..4.
- FRAME_MIN, 0, lowest legal coordinate on both axes.
- FRAME_MAX, 255, highest legal coordinate on both axes; must be < 2**OUT_WIDTH.

Ports:
- clk  in  1  posedge clock.
- rst  in  1  reset, asynchronous and active-low; all state clears while rst=0.
- enable  in  1  when 0, no new fetch is started; any in-flight segment completes.
- frame_start  in  1  single-cycle pulse that restarts the list at address 0.
- mem_addr  out  ADDR_WIDTH  list read address.
- mem_rd  out  1  read strobe, one cycle per word.
- mem_data  in  2+2*OUT_WIDTH  word = {op[1:0], x, y}; op encoding: 00 NOP, 01 POS, 10 DRAW, 11 END.
- busy  in  1  line drawer busy.
- go  out  1  one-cycle segment start pulse.
- o_start_x, o_start_y, o_end_x, o_end_y  out  OUT_WIDTH each  segment endpoints, stable from go until the next go.
- frame_done  out  1  one-cycle pulse when END is reached or the address wraps.
- frame_overrun  out  1  sticky; set when frame_start arrives while not in DONE/IDLE; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; cursor (x_prev,y_prev) = (FRAME_MIN,FRAME_MIN); mem_addr=0; state IDLE.
- IDLE: on frame_start with enable=1 -> FETCH, addr=0.
- FETCH: mem_rd=1 for one cycle -> WAITMEM.
- WAITMEM: counts MEM_LATENCY cycles; rd_data is captured on the last cycle -> DECODE.
- DECODE:
  - Clamp x and y independently to [FRAME_MIN, FRAME_MAX].
  - NOP: addr+1 -> FETCH.
  - POS: cursor := clamped (x,y); addr+1 -> FETCH; no go.
  - DRAW: start := cursor, end := clamped (x,y), cursor := end; -> GO.
  - END: -> DONE.
- GO: if busy=0, assert go for one cycle and register endpoints in the same cycle -> WAITDRAW; if busy=1, hold in GO.
- WAITDRAW: busy is ignored in the first cycle (drawer's busy latency). Then wait for busy=0 -> addr+1, FETCH; or -> IDLE if enable=0.
- DONE: frame_done pulses on entry. On frame_start -> FETCH with addr=0.
- Address wrap: after the word at address 2**ADDR_WIDTH-1 is processed, treat as END (frame_done pulses, addr returns to 0); the address never exceeds the depth.
- frame_start outside IDLE/DONE:
  - Set frame_overrun and latch a pending restart.
  - Finish the current memory read or segment (never abort a go/busy transaction).
  - Then jump to FETCH at addr 0; cursor resets to (FRAME_MIN,FRAME_MIN).
- frame_start in the same cycle as END decode: END wins (frame_done pulses), then the restart is taken immediately from DONE with no overrun.
- Restarting a frame resets the cursor; DRAW as the first command draws from (FRAME_MIN,FRAME_MIN).
- Latency, DRAW word: mem_rd to go = MEM_LATENCY+2 cycles when busy=0.

Optional Feature:
- Macro VECTOR_SEQ_BLANK_EN.
- Defined:
  - Adds output o_blank (1 bit, reset 0, registered alongside go).
  - POS issues a segment (start=cursor, end=target) with o_blank=1; DRAW issues o_blank=0.
  - POS therefore uses GO/WAITDRAW exactly like DRAW.
- Undefined: no o_blank port; POS only moves the cursor, with no go and no handshake.

Test Plan:
- MEM_LATENCY=1, list {POS(10,20), DRAW(50,60), END}, busy held 0 -> single go with start (10,20), end (50,60); frame_done exactly 1 cycle after that segment's WAITDRAW.
- DRAW(300-clamp case, OUT_WIDTH=9, FRAME_MAX=255): DRAW(400,5) after POS(0,0) -> end=(255,5).
- busy=1 held 20 cycles before go -> go not asserted until the cycle after busy falls; endpoints stable throughout.
- frame_start mid-segment (busy=1) -> current segment completes, frame_overrun=1, next mem_addr=0, next DRAW starts from (FRAME_MIN,FRAME_MIN).
- ADDR_WIDTH=2, four DRAW words and no END -> four go pulses, frame_done after address 3, no fifth read.
- rst driven low during WAITDRAW -> go/outputs/frame_overrun immediately 0, state IDLE; no go until the next frame_start.

Source files
------------

// File: rtl/vector_list_sequencer.sv
// Vector list sequencer: walks an {op,x,y} command list once per frame and feeds segments to a line drawer.
// Optional macro VECTOR_SEQ_BLANK_EN adds o_blank and turns POS into a blanked segment.
module vector_list_sequencer #(
   parameter int OUT_WIDTH   = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int MEM_LATENCY = 1,
   parameter int FRAME_MIN   = 0,
   parameter int FRAME_MAX   = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   frame_start,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic                   mem_rd,
   input  logic [2*OUT_WIDTH+1:0] mem_data,
   input  logic                   busy,
   output logic                   go,
   output logic [OUT_WIDTH-1:0]   o_start_x,
   output logic [OUT_WIDTH-1:0]   o_start_y,
   output logic [OUT_WIDTH-1:0]   o_end_x,
   output logic [OUT_WIDTH-1:0]   o_end_y,
`ifdef VECTOR_SEQ_BLANK_EN
   output logic                   o_blank,
`endif
   output logic                   frame_done,
   output logic                   frame_overrun
);
   localparam int W = OUT_WIDTH;
   localparam logic [W-1:0] FMIN     = W'(FRAME_MIN);
   localparam logic [W-1:0] FMAX     = W'(FRAME_MAX);
   localparam logic [1:0]   LAT_LAST = 2'(MEM_LATENCY - 1);
   localparam logic [1:0]   OP_POS = 2'b01, OP_DRAW = 2'b10, OP_END = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAITMEM, S_DECODE, S_GO, S_WAITDRAW, S_DONE} state_t;
   state_t state, state_n;

   logic [ADDR_WIDTH-1:0] addr;
   logic [1:0]            lat_cnt;
   logic [2*W+1:0]        word_q;
   logic [W-1:0]          cur_x, cur_y, seg_sx, seg_sy, seg_ex, seg_ey;
   logic [W-1:0]          xc, yc, nx_sx, nx_sy, nx_ex, nx_ey;
   logic [1:0]            op;
   logic                  pending, wd_first, is_move, is_seg, end_hit, outside, decode_move;
   logic                  fin, issue, restart, advance, enter_done, capture, clr_pend;

   function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
      return (v <= FMIN) ? FMIN : ((v >= FMAX) ? FMAX : v);
   endfunction

   assign op          = word_q[2*W+1 -: 2];
   assign xc          = clamp(word_q[2*W-1 -: W]);
   assign yc          = clamp(word_q[W-1:0]);
   assign is_move     = (op == OP_POS) || (op == OP_DRAW);
   assign decode_move = (state == S_DECODE) && !pending && is_move;
   assign end_hit     = (state == S_DECODE) && !pending && (op == OP_END);
   assign outside     = (state != S_IDLE) && (state != S_DONE);
   assign mem_addr    = addr;

   // A segment issued straight from DECODE has not yet landed in seg_*
   assign nx_sx = (state == S_DECODE) ? cur_x : seg_sx;
   assign nx_sy = (state == S_DECODE) ? cur_y : seg_sy;
   assign nx_ex = (state == S_DECODE) ? xc    : seg_ex;
   assign nx_ey = (state == S_DECODE) ? yc    : seg_ey;

`ifdef VECTOR_SEQ_BLANK_EN
   logic seg_blank, nx_blank;
   assign is_seg   = is_move;
   assign nx_blank = (state == S_DECODE) ? (op == OP_POS) : seg_blank;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_blank <= 1'b0;
         o_blank   <= 1'b0;
      end else begin
         if (decode_move) seg_blank <= (op == OP_POS);
         if (issue)       o_blank   <= nx_blank;
      end
   end
`else
   assign is_seg = (op == OP_DRAW);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n    = state;
      mem_rd     = 1'b0;
      issue      = 1'b0;
      restart    = 1'b0;
      advance    = 1'b0;
      enter_done = 1'b0;
      capture    = 1'b0;
      clr_pend   = 1'b0;
      fin        = 1'b0;
      case (state)
         S_IDLE:    if (frame_start && enable) begin restart = 1'b1; state_n = S_FETCH; end
         S_FETCH:   begin mem_rd = 1'b1; state_n = S_WAITMEM; end
         S_WAITMEM: if (lat_cnt == LAT_LAST) begin capture = 1'b1; state_n = S_DECODE; end
         S_DECODE:
            if (pending) fin = 1'b1;
            else if (op == OP_END) begin enter_done = 1'b1; state_n = S_DONE; end
            else if (is_seg) begin
               if (!busy) begin issue = 1'b1; state_n = S_WAITDRAW; end
               else state_n = S_GO;
            end else fin = 1'b1;
         S_GO:       if (!busy) begin issue = 1'b1; state_n = S_WAITDRAW; end
         // first WAITDRAW cycle is the drawer's busy latency
         S_WAITDRAW: if (!wd_first && !busy) fin = 1'b1;
         S_DONE:     if ((frame_start || pending) && enable) begin restart = 1'b1; state_n = S_FETCH; end
         default:    state_n = S_IDLE;
      endcase
      if (fin) begin
         if (pending || frame_start) begin
            clr_pend = 1'b1;
            if (enable) begin restart = 1'b1; state_n = S_FETCH; end
            else state_n = S_IDLE;
         end else if (&addr) begin
            enter_done = 1'b1;
            state_n    = S_DONE;
         end else if (enable) begin
            advance = 1'b1;
            state_n = S_FETCH;
         end else state_n = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr          <= '0;
         lat_cnt       <= '0;
         word_q        <= '0;
         cur_x         <= FMIN;
         cur_y         <= FMIN;
         seg_sx        <= '0;
         seg_sy        <= '0;
         seg_ex        <= '0;
         seg_ey        <= '0;
         pending       <= 1'b0;
         wd_first      <= 1'b0;
         go            <= 1'b0;
         o_start_x     <= '0;
         o_start_y     <= '0;
         o_end_x       <= '0;
         o_end_y       <= '0;
         frame_done    <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         go         <= issue;
         wd_first   <= issue;
         frame_done <= enter_done;
         lat_cnt    <= (state == S_WAITMEM) ? lat_cnt + 2'd1 : 2'd0;
         if (capture) word_q <= mem_data;
         if (decode_move) begin
            seg_sx <= cur_x;
            seg_sy <= cur_y;
            seg_ex <= xc;
            seg_ey <= yc;
            cur_x  <= xc;
            cur_y  <= yc;
         end
         if (issue) begin
            o_start_x <= nx_sx;
            o_start_y <= nx_sy;
            o_end_x   <= nx_ex;
            o_end_y   <= nx_ey;
         end
         // restart comes last so it overrides a same-cycle cursor move
         if (restart) begin
            addr  <= '0;
            cur_x <= FMIN;
            cur_y <= FMIN;
         end else if (advance) addr <= addr + ADDR_WIDTH'(1);
         else if (enter_done)  addr <= '0;
         if (restart || clr_pend)           pending <= 1'b0;
         else if (frame_start && outside)   pending <= 1'b1;
         if (frame_start && outside && !end_hit) frame_overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vector_list_sequencer.sv
// Directed bench for vector_list_sequencer: 4-word list memory, 9-bit coordinates clamped to 0..255.
module tb_vector_list_sequencer;
   localparam int OW = 9, AW = 2, LAT = 1;
   localparam logic [1:0] NOP = 2'd0, POS = 2'd1, DRAW = 2'd2, ENDC = 2'd3;

   logic clk = 1'b0, rst = 1'b0, enable = 1'b1, frame_start = 1'b0, busy = 1'b0;
   logic [AW-1:0]   mem_addr;
   logic            mem_rd, go, frame_done, frame_overrun;
   logic [2*OW+1:0] mem_data = '0;
   logic [OW-1:0]   sx, sy, ex, ey;
`ifdef VECTOR_SEQ_BLANK_EN
   logic blank;
`endif
   logic [2*OW+1:0] mem [4];

   int errors = 0, checks = 0, cyc = 0;
   int go_cnt = 0, rd_cnt = 0, fd_cnt = 0, go_cyc = 0, fd_cyc = 0;
   logic [OW-1:0] h_sx [64], h_sy [64], h_ex [64], h_ey [64];
   logic [AW-1:0] h_ra [128];
   int            h_rc [128];

   vector_list_sequencer #(.OUT_WIDTH(OW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT),
                           .FRAME_MIN(0), .FRAME_MAX(255)) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy), .go(go),
      .o_start_x(sx), .o_start_y(sy), .o_end_x(ex), .o_end_y(ey),
`ifdef VECTOR_SEQ_BLANK_EN
      .o_blank(blank),
`endif
      .frame_done(frame_done), .frame_overrun(frame_overrun));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   always @(negedge clk) begin
      if (go) begin
         if (go_cnt < 64) begin
            h_sx[go_cnt] = sx; h_sy[go_cnt] = sy; h_ex[go_cnt] = ex; h_ey[go_cnt] = ey;
         end
         go_cnt = go_cnt + 1;
         go_cyc = cyc;
      end
      if (mem_rd) begin
         if (rd_cnt < 128) begin h_ra[rd_cnt] = mem_addr; h_rc[rd_cnt] = cyc; end
         rd_cnt = rd_cnt + 1;
      end
      if (frame_done) begin fd_cnt = fd_cnt + 1; fd_cyc = cyc; end
   end

   function automatic logic [2*OW+1:0] mk(input logic [1:0] op, input int x, input int y);
      return {op, OW'(x), OW'(y)};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic pulse_fs();
      tick(1); frame_start = 1'b1;
      tick(1); frame_start = 1'b0;
   endtask

   task automatic wait_go(input int n);
      int k = 0;
      while (go_cnt < n && k < 300) begin tick(1); k++; end
      checks++;
      if (go_cnt < n) begin errors++; $display("FAIL wait_go timeout: go_cnt=%0d expected %0d", go_cnt, n); end
   endtask

   task automatic wait_fd(input int n);
      int k = 0;
      while (fd_cnt < n && k < 300) begin tick(1); k++; end
      checks++;
      if (fd_cnt < n) begin errors++; $display("FAIL wait_fd timeout: fd_cnt=%0d expected %0d", fd_cnt, n); end
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if ({go, mem_rd, frame_done, frame_overrun} !== 4'b0) begin errors++;
         $display("FAIL reset_ctl: got %b expected 0000", {go, mem_rd, frame_done, frame_overrun}); end
      checks++;
      if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
      checks++;
      if ({sx, sy, ex, ey} !== '0) begin errors++; $display("FAIL reset_pts: got %h expected 0", {sx, sy, ex, ey}); end
      rst = 1'b1;
      tick(5);
      checks++;
      if (go_cnt !== 0 || rd_cnt !== 0) begin errors++;
         $display("FAIL idle_quiet: go=%0d rd=%0d expected 0 0", go_cnt, rd_cnt); end
   endtask

   task automatic test_basic();
      int gb = go_cnt, rb = rd_cnt, fb = fd_cnt;
      mem[0] = mk(POS, 10, 20); mem[1] = mk(DRAW, 50, 60); mem[2] = mk(ENDC, 0, 0); mem[3] = mk(NOP, 0, 0);
      pulse_fs();
      wait_fd(fb + 1);
      tick(10);
      checks++;
      if (go_cnt - gb !== 1) begin errors++; $display("FAIL basic_gos: got %0d expected 1", go_cnt - gb); end
      checks++;
      if ({h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]} !== {9'd10, 9'd20, 9'd50, 9'd60}) begin errors++;
         $display("FAIL basic_seg: got %0d,%0d-%0d,%0d expected 10,20-50,60", h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]); end
      checks++;
      if (go_cyc - h_rc[rb+1] !== LAT + 2) begin errors++;
         $display("FAIL basic_latency: got %0d expected %0d", go_cyc - h_rc[rb+1], LAT + 2); end
      checks++;
      if (rd_cnt - rb !== 3 || h_ra[rb+2] !== 2'd2) begin errors++;
         $display("FAIL basic_reads: got %0d reads last addr %0d expected 3 reads addr 2", rd_cnt - rb, h_ra[rb+2]); end
      checks++;
      if (fd_cnt - fb !== 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", fd_cnt - fb); end
      checks++;
      if ({ex, ey} !== {9'd50, 9'd60}) begin errors++; $display("FAIL basic_hold: got %0d,%0d expected 50,60", ex, ey); end
   endtask

   task automatic test_clamp();
      int gb = go_cnt, fb = fd_cnt;
      mem[0] = mk(POS, 0, 0); mem[1] = mk(DRAW, 400, 5); mem[2] = mk(DRAW, 7, 300); mem[3] = mk(ENDC, 0, 0);
      pulse_fs();
      wait_fd(fb + 1);
      tick(3);
      checks++;
      if (go_cnt - gb !== 2) begin errors++; $display("FAIL clamp_gos: got %0d expected 2", go_cnt - gb); end
      checks++;
      if ({h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]} !== {9'd0, 9'd0, 9'd255, 9'd5}) begin errors++;
         $display("FAIL clamp_x: got %0d,%0d-%0d,%0d expected 0,0-255,5", h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]); end
      checks++;
      if ({h_sx[gb+1], h_sy[gb+1], h_ex[gb+1], h_ey[gb+1]} !== {9'd255, 9'd5, 9'd7, 9'd255}) begin errors++;
         $display("FAIL clamp_y: got %0d,%0d-%0d,%0d expected 255,5-7,255", h_sx[gb+1], h_sy[gb+1], h_ex[gb+1], h_ey[gb+1]); end
   endtask

   task automatic test_busy_hold();
      int gb = go_cnt, fb = fd_cnt, bc;
      logic [4*OW-1:0] pe;
      logic stable = 1'b1;
      mem[0] = mk(DRAW, 30, 40); mem[1] = mk(ENDC, 0, 0); mem[2] = mk(NOP, 0, 0); mem[3] = mk(NOP, 0, 0);
      pe = {sx, sy, ex, ey};
      busy = 1'b1;
      pulse_fs();
      for (int i = 0; i < 20; i++) begin tick(1); if ({sx, sy, ex, ey} !== pe) stable = 1'b0; end
      checks++;
      if (go_cnt !== gb) begin errors++; $display("FAIL busy_nogo: got %0d gos expected 0", go_cnt - gb); end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("FAIL busy_stable: got %b expected 1", stable); end
      busy = 1'b0;
      bc = cyc;
      wait_go(gb + 1);
      checks++;
      if (go_cyc !== bc + 1) begin errors++; $display("FAIL busy_release: go at %0d expected %0d", go_cyc, bc + 1); end
      checks++;
      if ({h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]} !== {9'd0, 9'd0, 9'd30, 9'd40}) begin errors++;
         $display("FAIL busy_seg: got %0d,%0d-%0d,%0d expected 0,0-30,40", h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]); end
      wait_fd(fb + 1);
   endtask

   task automatic test_overrun();
      int gb = go_cnt, fb = fd_cnt, rb;
      mem[0] = mk(DRAW, 30, 40); mem[1] = mk(DRAW, 70, 80); mem[2] = mk(DRAW, 90, 100); mem[3] = mk(ENDC, 0, 0);
      pulse_fs();
      wait_go(gb + 1);
      busy = 1'b1;
      tick(3);
      checks++;
      if (frame_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clean: got %b expected 0", frame_overrun); end
      rb = rd_cnt;
      pulse_fs();
      tick(2);
      checks++;
      if (frame_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", frame_overrun); end
      checks++;
      if (go_cnt !== gb + 1 || rd_cnt !== rb) begin errors++;
         $display("FAIL ovr_hold: gos=%0d reads=%0d expected 1 0", go_cnt - gb, rd_cnt - rb); end
      busy = 1'b0;
      wait_go(gb + 2);
      checks++;
      if (h_ra[rb] !== 2'd0) begin errors++; $display("FAIL ovr_addr: got %0d expected 0", h_ra[rb]); end
      checks++;
      if ({h_sx[gb+1], h_sy[gb+1], h_ex[gb+1], h_ey[gb+1]} !== {9'd0, 9'd0, 9'd30, 9'd40}) begin errors++;
         $display("FAIL ovr_cursor: got %0d,%0d-%0d,%0d expected 0,0-30,40", h_sx[gb+1], h_sy[gb+1], h_ex[gb+1], h_ey[gb+1]); end
      wait_fd(fb + 1);
      tick(3);
      checks++;
      if (go_cnt - gb !== 4 || frame_overrun !== 1'b1) begin errors++;
         $display("FAIL ovr_tail: gos=%0d ovr=%b expected 4 1", go_cnt - gb, frame_overrun); end
   endtask

   task automatic test_wrap();
      int gb = go_cnt, rb = rd_cnt, fb = fd_cnt;
      for (int i = 0; i < 4; i++) mem[i] = mk(DRAW, i + 1, i + 1);
      pulse_fs();
      wait_fd(fb + 1);
      tick(20);
      checks++;
      if (go_cnt - gb !== 4) begin errors++; $display("FAIL wrap_gos: got %0d expected 4", go_cnt - gb); end
      checks++;
      if ({h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]} !== {9'd0, 9'd0, 9'd1, 9'd1}) begin errors++;
         $display("FAIL wrap_first: got %0d,%0d-%0d,%0d expected 0,0-1,1", h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]); end
      checks++;
      if ({h_sx[gb+3], h_sy[gb+3], h_ex[gb+3], h_ey[gb+3]} !== {9'd3, 9'd3, 9'd4, 9'd4}) begin errors++;
         $display("FAIL wrap_last: got %0d,%0d-%0d,%0d expected 3,3-4,4", h_sx[gb+3], h_sy[gb+3], h_ex[gb+3], h_ey[gb+3]); end
      checks++;
      if (fd_cnt - fb !== 1 || fd_cyc - go_cyc !== 2) begin errors++;
         $display("FAIL wrap_done: count=%0d offset=%0d expected 1 2", fd_cnt - fb, fd_cyc - go_cyc); end
      checks++;
      if (rd_cnt - rb !== 4 || mem_addr !== 2'd0) begin errors++;
         $display("FAIL wrap_reads: reads=%0d addr=%0d expected 4 0", rd_cnt - rb, mem_addr); end
   endtask

   task automatic test_reset_mid();
      int gb = go_cnt, fb;
      mem[0] = mk(DRAW, 5, 6); mem[1] = mk(ENDC, 0, 0); mem[2] = mk(NOP, 0, 0); mem[3] = mk(NOP, 0, 0);
      pulse_fs();
      wait_go(gb + 1);
      busy = 1'b1;
      tick(1);
      rst = 1'b0;
      #1;
      checks++;
      if ({go, mem_rd, frame_done, frame_overrun} !== 4'b0) begin errors++;
         $display("FAIL rstmid_ctl: got %b expected 0000", {go, mem_rd, frame_done, frame_overrun}); end
      checks++;
      if ({sx, sy, ex, ey} !== '0 || mem_addr !== '0) begin errors++;
         $display("FAIL rstmid_pts: got %h addr %0d expected 0 0", {sx, sy, ex, ey}, mem_addr); end
      tick(1);
      rst  = 1'b1;
      busy = 1'b0;
      gb   = go_cnt;
      tick(20);
      checks++;
      if (go_cnt !== gb) begin errors++; $display("FAIL rstmid_idle: got %0d gos expected 0", go_cnt - gb); end
      fb = fd_cnt;
      pulse_fs();
      wait_go(gb + 1);
      checks++;
      if ({h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]} !== {9'd0, 9'd0, 9'd5, 9'd6}) begin errors++;
         $display("FAIL rstmid_seg: got %0d,%0d-%0d,%0d expected 0,0-5,6", h_sx[gb], h_sy[gb], h_ex[gb], h_ey[gb]); end
      wait_fd(fb + 1);
   endtask

   task automatic test_end_restart();
      int fb = fd_cnt, rb = rd_cnt;
      mem[0] = mk(ENDC, 0, 0); mem[1] = mk(NOP, 0, 0); mem[2] = mk(NOP, 0, 0); mem[3] = mk(NOP, 0, 0);
      tick(1); frame_start = 1'b1;
      tick(1); frame_start = 1'b0;
      tick(2); frame_start = 1'b1;   // lands on the END decode cycle
      tick(1); frame_start = 1'b0;
      tick(15);
      checks++;
      if (fd_cnt - fb !== 2) begin errors++; $display("FAIL endrs_done: got %0d expected 2", fd_cnt - fb); end
      checks++;
      if (rd_cnt - rb !== 2) begin errors++; $display("FAIL endrs_reads: got %0d expected 2", rd_cnt - rb); end
      checks++;
      if (frame_overrun !== 1'b0) begin errors++; $display("FAIL endrs_ovr: got %b expected 0", frame_overrun); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_busy_hold();
      test_overrun();
      test_wrap();
      test_reset_mid();
      test_end_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
